muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Iterative multiply/divide controller for the EX stage of the pipelined MIPS core. Accepts MULT/MULTU/DIV/DIVU from the decoder (same funct field the ALU decoder consumes), runs a 32-step shift-add or restoring-divide sequence, and raises `busy` so the hazard unit stalls the pipeline. Owns the HI/LO architectural registers and also handles the single-cycle MTHI/MTLO writes; MFHI/MFLO read `hi`/`lo` directly.

## Interface
- No parameters; operand width fixed at 32.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: EX-stage instruction valid with R-type funct below.
- `funct` in 6: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO; other values ignored.
- `a` in 32: rs operand (multiplicand / dividend / MTHI-MTLO data).
- `b` in 32: rt operand (multiplier / divisor).
- `busy` out 1: stall request, high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse; new `hi`/`lo` valid this cycle.
- `div_by_zero` out 1: pulses with `done` when DIV/DIVU had `b`=0.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE: `start` with a mult/div funct latches operands, sets the signed flag (MULT/DIV), and moves to RUN with count=0. DIV/DIVU with `b`=0 goes directly to FIX.
- IDLE: `start` with MTHI/MTLO writes `a` into `hi`/`lo` at the clock edge. State stays IDLE; no `busy`, no `done`.
- Signed ops run on magnitudes (two's-complement negate when the operand MSB is set). Operand signs are kept for FIX.
- RUN, multiply: 64-bit {acc,mplr} shift-add, one bit per cycle. Uses a 33-bit sum so there is no carry loss.
- RUN, divide: restoring. Remainder shifts left, 33-bit trial subtract of the divisor, quotient bit = no-borrow.
- RUN → FIX after count=31. That is 32 RUN cycles.
- FIX, multiply: negate the 64-bit product if operand signs differ. `hi` = upper word, `lo` = lower word.
- FIX, divide: quotient negated if signs differ, remainder takes the dividend's sign. `lo` = quotient, `hi` = remainder. All arithmetic is mod 2^32, so 0x80000000 / -1 gives `lo`=0x80000000, `hi`=0.
- FIX, divide-by-zero: `hi` = `a`, `lo` = 0xFFFFFFFF, `div_by_zero` set.
- FIX → IDLE. `done` (and `div_by_zero` if applicable) is registered and high in the first IDLE cycle.
- `start` while `busy`: ignored. The pipeline guarantees it does not occur.
- `start` in the same cycle as `done`: accepted normally.
- `hi`/`lo` hold their value between completions and MT writes.

## Timing
- Reset (asynchronous, any state, including mid-RUN): state IDLE, count 0, `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0. The partial result is discarded.
- `start` sampled in cycle N (IDLE).
- Normal op: `busy` high in cycles N+1..N+33 (RUN N+1..N+32, FIX N+33). `done` high in N+34 with results visible. Latency = 34 cycles.
- Divide-by-zero: FIX in N+1, `done` and `div_by_zero` in N+2.
- MTHI/MTLO: register updated at the end of cycle N, visible in N+1.
- `busy` is a registered state decode with no combinational path from `start`. The hazard unit combines `start` itself for the issue cycle.

## Structure
- Shared package `mips_pkg` holds:
  - funct constants (FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO);
  - alucontrol constants already used by the ALU decoder (ALU_ADD=010, ALU_SUB=110, ALU_AND=000, ALU_OR=001, ALU_SLT=111);
  - the FSM state enum.
- One sub-module: `muldiv_step`, combinational, a single iteration. Inputs: acc, shift register, operand, mode. Outputs: next acc / next shift register, using the 33-bit add/sub.
- Controller top holds the FSM, counter, sign flags, HI/LO and FIX logic.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF at N → `done` at N+34, `hi`=0xFFFFFFFE, `lo`=0x00000001, `busy` high N+1..N+33.
- MULT a=-3, b=5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. DIV a=-7, b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0. DIVU a=100, b=7 → `lo`=14, `hi`=2.
- DIVU a=100, b=0 → `done` and `div_by_zero` at N+2, `hi`=100, `lo`=0xFFFFFFFF.
- Assert `reset_n`=0 at RUN count 10 → `busy`/`hi`/`lo` 0 immediately. Next MULTU 6×7 after release → `lo`=42 at +34.
- MTLO a=0x1234 → `lo`=0x1234 next cycle, no `busy`/`done`. Back-to-back: new MULTU issued in the `done` cycle is accepted, and the second `done` comes 34 cycles later.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core constants and mul/div controller state type
package mips_pkg;

  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  // Two's-complement magnitude when the caller says the value is negative.
  function automatic logic [31:0] abs_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply or restoring-divide iteration
module muldiv_step (
  input  logic [31:0] acc,
  input  logic [31:0] sreg,
  input  logic [31:0] opnd,
  input  logic        div_mode,
  output logic [31:0] acc_next,
  output logic [31:0] sreg_next
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic        borrow;

  always_comb begin
    sum     = {1'b0, acc} + (sreg[0] ? {1'b0, opnd} : 33'd0);
    shifted = {acc, sreg[31]};
    trial   = shifted - {1'b0, opnd};
    // Remainder stays below the divisor, so a set shifted[32] can never borrow.
    borrow  = ~shifted[32] & trial[32];
    if (div_mode) begin
      acc_next  = borrow ? shifted[31:0] : trial[31:0];
      sreg_next = {sreg[30:0], ~borrow};
    end else begin
      acc_next  = sum[32:1];
      sreg_next = {sum[0], sreg[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative MULT/DIV controller owning the HI/LO registers
module muldiv_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_t   state, state_next;
  logic [4:0]  count;
  logic [31:0] acc, sreg, opnd;
  logic [31:0] acc_step, sreg_step;
  logic        is_div, neg_res, neg_rem, dz;
  logic        op_md, op_div, op_signed, b_zero;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign op_div    = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
  assign op_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign op_md     = start && (op_div || (funct == FUNCT_MULT) || (funct == FUNCT_MULTU));
  assign b_zero    = (b == 32'd0);

  assign prod_fix = neg_res ? -{acc, sreg} : {acc, sreg};
  assign quo_fix  = neg_res ? -sreg : sreg;
  assign rem_fix  = neg_rem ? -acc : acc;

  muldiv_step u_step (
    .acc       (acc),
    .sreg      (sreg),
    .opnd      (opnd),
    .div_mode  (is_div),
    .acc_next  (acc_step),
    .sreg_next (sreg_step)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= MD_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (op_md) state_next = (op_div && b_zero) ? MD_FIX : MD_RUN;
      MD_RUN:  if (count == 5'd31) state_next = MD_FIX;
      MD_FIX:  state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != MD_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= 5'd0;
      acc         <= 32'd0;
      sreg        <= 32'd0;
      opnd        <= 32'd0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      dz          <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= (state == MD_FIX);
      div_by_zero <= (state == MD_FIX) && dz;
      case (state)
        MD_IDLE: begin
          count <= 5'd0;
          if (op_md) begin
            acc     <= 32'd0;
            is_div  <= op_div;
            dz      <= op_div && b_zero;
            neg_res <= op_signed && (a[31] ^ b[31]);
            neg_rem <= op_signed && a[31];
            // Dividend goes through the shift register; multiplier does for MULT.
            if (op_div && b_zero) begin
              sreg <= a;
              opnd <= b;
            end else if (op_div) begin
              sreg <= abs_if(a, op_signed && a[31]);
              opnd <= abs_if(b, op_signed && b[31]);
            end else begin
              sreg <= abs_if(b, op_signed && b[31]);
              opnd <= abs_if(a, op_signed && a[31]);
            end
          end else if (start && funct == FUNCT_MTHI) begin
            hi <= a;
          end else if (start && funct == FUNCT_MTLO) begin
            lo <= a;
          end
        end
        MD_RUN: begin
          acc   <= acc_step;
          sreg  <= sreg_step;
          count <= count + 5'd1;
        end
        MD_FIX: begin
          if (dz) begin
            hi <= sreg;
            lo <= 32'hFFFF_FFFF;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - randomized self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  funct = 6'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .funct       (funct),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_md(input logic [5:0] f);
    return f == FUNCT_MULT || f == FUNCT_MULTU || f == FUNCT_DIV || f == FUNCT_DIVU;
  endfunction

  task automatic ref_result(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                            output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
    logic [63:0] p;
    longint sx, sy, q, r;
    sx = $signed(x);
    sy = $signed(y);
    rdz = 1'b0;
    rh = 32'd0;
    rl = 32'd0;
    if ((f == FUNCT_DIV || f == FUNCT_DIVU) && y == 32'd0) begin
      rdz = 1'b1;
      rh = x;
      rl = 32'hFFFF_FFFF;
    end else if (f == FUNCT_MULTU) begin
      p = {32'd0, x} * {32'd0, y};
      rh = p[63:32];
      rl = p[31:0];
    end else if (f == FUNCT_MULT) begin
      q = sx * sy;
      p = q;
      rh = p[63:32];
      rl = p[31:0];
    end else if (f == FUNCT_DIVU) begin
      rl = x / y;
      rh = x % y;
    end else begin
      q = sx / sy;
      r = sx % sy;
      rl = q[31:0];
      rh = r[31:0];
    end
  endtask

  // Timeline model: an issued op keeps the unit busy for m_rem cycles, then retires.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  logic        m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
  int          m_rem = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi = 32'd0; m_lo = 32'd0; m_done = 1'b0; m_dz = 1'b0; m_rem = 0;
    end else begin
      m_done = 1'b0;
      m_dz = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_dz = p_dz;
        end
      end else if (start) begin
        if (funct == FUNCT_MTHI) m_hi = a;
        else if (funct == FUNCT_MTLO) m_lo = a;
        else if (is_md(funct)) begin
          ref_result(funct, a, b, p_hi, p_lo, p_dz);
          m_rem = p_dz ? 1 : 33;
        end
      end
    end
  end

  initial begin
    @(posedge reset_n);
    forever begin
      @(negedge clk);
      chk("busy", busy, m_rem > 0);
      chk("done", done, m_done);
      chk("div_by_zero", div_by_zero, m_dz);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                       input bit noise, output int lat, output int nbusy);
    start = 1'b1; funct = f; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; funct = 6'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    nbusy = 0;
    if (is_md(f)) begin
      while (!done && lat < 60) begin
        if (busy) nbusy++;
        if (noise && busy) start = 1'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        lat++;
      end
      chk("done_seen", done, 1'b1);
    end
  endtask

  task automatic run_lit(input string name, input logic [5:0] f, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                         input logic edz, input int elat);
    int lat, nbusy;
    issue(f, x, y, 1'b0, lat, nbusy);
    chk({name, "_latency"}, lat, elat);
    chk({name, "_busy_cycles"}, nbusy, elat - 1);
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
    chk({name, "_dz"}, div_by_zero, edz);
    chk({name, "_model_hi"}, m_hi, eh);
    chk({name, "_model_lo"}, m_lo, el);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  ops [6];
    logic [31:0] sp [5];
    logic [31:0] x, y;
    logic [5:0]  f;
    int lat, nbusy;
    ops = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO};
    sp  = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_dz", div_by_zero, 1'b0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    run_lit("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, 34);
    run_lit("mult_neg", FUNCT_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34);
    run_lit("div_neg", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
    run_lit("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34);
    @(posedge clk); #1;
    run_lit("divu", FUNCT_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);
    run_lit("divu_zero", FUNCT_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 2);

    start = 1'b1; funct = FUNCT_MULTU; a = 32'hDEAD; b = 32'hBEEF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrun_reset_busy", busy, 1'b0);
    chk("midrun_reset_hi", hi, 32'd0);
    chk("midrun_reset_lo", lo, 32'd0);
    chk("midrun_reset_done", done, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;
    run_lit("multu_after_reset", FUNCT_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 34);

    issue(FUNCT_MTLO, 32'h1234, 32'd0, 1'b0, lat, nbusy);
    chk("mtlo_lo", lo, 32'h1234);
    chk("mtlo_busy", busy, 1'b0);
    chk("mtlo_done", done, 1'b0);
    issue(FUNCT_MTHI, 32'hABCD, 32'd0, 1'b0, lat, nbusy);
    chk("mthi_hi", hi, 32'hABCD);
    chk("mthi_lo_kept", lo, 32'h1234);

    run_lit("b2b_first", FUNCT_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 34);
    run_lit("b2b_second", FUNCT_MULTU, 32'h1_0000, 32'h1_0000, 32'd1, 32'd0, 1'b0, 34);

    for (int i = 0; i < 40; i++) begin
      f = ops[$urandom_range(0, 5)];
      x = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) y = y & 32'hFF;
      issue(f, x, y, 1'b1, lat, nbusy);
      if (is_md(f))
        chk("rand_latency", lat, ((f == FUNCT_DIV || f == FUNCT_DIVU) && y == 32'd0) ? 2 : 34);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
